// File: rtl/run_monitor_if.sv
// Signal bundle between a CPU trace source / snapshot consumer and run_monitor.
// The slave side is the monitor itself; the master side drives the CPU trace,
// arm and out_ready, and observes the snapshot stream and status flags.
interface run_monitor_if #(
  parameter int PC_WIDTH  = 12,
  parameter int NREG      = 16,
  parameter int REG_WIDTH = 4
);
  logic                      sync;
  logic [PC_WIDTH-1:0]       pc;
  logic [REG_WIDTH-1:0]      acc;
  logic                      carry;
  logic [NREG*REG_WIDTH-1:0] regs;
  logic                      arm;
  logic                      out_valid;
  logic                      out_ready;
  logic [REG_WIDTH-1:0]      out_data;
  logic                      out_last;
  logic                      busy;
  logic                      done;
  logic                      halted;
  logic                      timeout;

  modport master (
    output sync, pc, acc, carry, regs, arm, out_ready,
    input  out_valid, out_data, out_last, busy, done, halted, timeout
  );

  modport slave (
    input  sync, pc, acc, carry, regs, arm, out_ready,
    output out_valid, out_data, out_last, busy, done, halted, timeout
  );
endinterface

// File: rtl/run_monitor.sv
// Run monitor: after arm, counts clocks and instructions of a CPU, stops on a
// pc threshold or an instruction budget, freezes a snapshot of the CPU state
// and streams it out one REG_WIDTH word at a time over a valid/ready channel.
module run_monitor #(
  parameter int PC_WIDTH  = 12,
  parameter int ROM_SIZE  = 256,
  parameter int NREG      = 16,
  parameter int REG_WIDTH = 4,
  parameter int CNT_WIDTH = 32,
  parameter int MAX_INSTR = 4096
) (
  input logic          clock,
  input logic          reset,
  run_monitor_if.slave bus
);
  localparam int CNT_WORDS   = CNT_WIDTH / REG_WIDTH;
  localparam int NWORDS      = 2 + NREG + CNT_WORDS;
  localparam int IDX_WIDTH   = $clog2(NWORDS);
  localparam int INSTR_WIDTH = $clog2(MAX_INSTR + 1);
  localparam logic [IDX_WIDTH-1:0]   LAST_IDX    = IDX_WIDTH'(NWORDS - 1);
  localparam logic [INSTR_WIDTH-1:0] INSTR_LIMIT = INSTR_WIDTH'(MAX_INSTR - 1);
  localparam logic [PC_WIDTH:0]      PC_LIMIT    = (PC_WIDTH + 1)'(ROM_SIZE);
  localparam logic [CNT_WIDTH-1:0]   CNT_MAX     = {CNT_WIDTH{1'b1}};

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                    state_reg, state_next;
  logic [CNT_WIDTH-1:0]      cycle_reg, cycle_next;
  logic [INSTR_WIDTH-1:0]    instr_reg, instr_next;
  logic                      halted_reg, halted_next;
  logic                      timeout_reg, timeout_next;
  logic [IDX_WIDTH-1:0]      idx_reg, idx_next;
  logic                      capture;
  logic [REG_WIDTH-1:0]      acc_snap_reg;
  logic                      carry_snap_reg;
  logic [NREG*REG_WIDTH-1:0] regs_snap_reg;
  logic [CNT_WIDTH-1:0]      cnt_snap_reg;
  logic                      pc_hit;
  logic [REG_WIDTH-1:0]      word_mux [2**IDX_WIDTH];

  // pc compared one bit wider so ROM_SIZE == 2**PC_WIDTH is representable
  assign pc_hit = {1'b0, bus.pc} >= PC_LIMIT;

  // Output word order: acc, carry, registers 0..NREG-1, cycle count LS word first;
  // unused index slots read as zero.
  assign word_mux[0] = acc_snap_reg;
  assign word_mux[1] = REG_WIDTH'(carry_snap_reg);
  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_reg_words
      assign word_mux[2 + gi] = regs_snap_reg[gi*REG_WIDTH +: REG_WIDTH];
    end
    for (gi = 0; gi < CNT_WORDS; gi++) begin : g_cnt_words
      assign word_mux[2 + NREG + gi] = cnt_snap_reg[gi*REG_WIDTH +: REG_WIDTH];
    end
    for (gi = NWORDS; gi < 2**IDX_WIDTH; gi++) begin : g_pad_words
      assign word_mux[gi] = '0;
    end
  endgenerate

  assign bus.busy      = (state_reg == RUN);
  assign bus.done      = (state_reg == DONE);
  assign bus.out_valid = (state_reg == DRAIN);
  assign bus.out_last  = (state_reg == DRAIN) && (idx_reg == LAST_IDX);
  assign bus.out_data  = (state_reg == DRAIN) ? word_mux[idx_reg] : '0;
  assign bus.halted    = halted_reg;
  assign bus.timeout   = timeout_reg;

  // Next-state logic: arm handling, run counters, stop detection, drain indexing
  always_comb begin
    state_next   = state_reg;
    cycle_next   = cycle_reg;
    instr_next   = instr_reg;
    halted_next  = halted_reg;
    timeout_next = timeout_reg;
    idx_next     = idx_reg;
    capture      = 1'b0;
    case (state_reg)
      IDLE, DONE: begin
        if (bus.arm) begin
          state_next   = RUN;
          cycle_next   = '0;
          instr_next   = '0;
          halted_next  = 1'b0;
          timeout_next = 1'b0;
          idx_next     = '0;
        end
      end
      RUN: begin
        if (cycle_reg != CNT_MAX) cycle_next = cycle_reg + 1'b1;
        if (bus.sync) begin
          instr_next = instr_reg + 1'b1;
          // pc threshold wins over the budget when both hit on the same sync
          if (pc_hit) begin
            capture     = 1'b1;
            halted_next = 1'b1;
            state_next  = DRAIN;
            idx_next    = '0;
          end else if (instr_reg == INSTR_LIMIT) begin
            capture      = 1'b1;
            timeout_next = 1'b1;
            state_next   = DRAIN;
            idx_next     = '0;
          end
        end
      end
      DRAIN: begin
        if (bus.out_ready) begin
          if (idx_reg == LAST_IDX) begin
            state_next = DONE;
            idx_next   = '0;
          end else begin
            idx_next = idx_reg + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Control state register with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg   <= IDLE;
      cycle_reg   <= '0;
      instr_reg   <= '0;
      halted_reg  <= 1'b0;
      timeout_reg <= 1'b0;
      idx_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      cycle_reg   <= cycle_next;
      instr_reg   <= instr_next;
      halted_reg  <= halted_next;
      timeout_reg <= timeout_next;
      idx_reg     <= idx_next;
    end
  end

  // Snapshot holds the CPU state and pre-increment cycle count of the stop cycle
  always_ff @(posedge clock) begin
    if (!reset) begin
      acc_snap_reg   <= '0;
      carry_snap_reg <= 1'b0;
      regs_snap_reg  <= '0;
      cnt_snap_reg   <= '0;
    end else if (capture) begin
      acc_snap_reg   <= bus.acc;
      carry_snap_reg <= bus.carry;
      regs_snap_reg  <= bus.regs;
      cnt_snap_reg   <= cycle_reg;
    end
  end
endmodule

// File: tb/tb_run_monitor.sv
// Bench for run_monitor: two instances (default parameters, and a small one with
// MAX_INSTR=4 / CNT_WIDTH=8) see identical stimulus. A directed table plus
// randomized runs are checked against a trace-level reference model.
module tb_run_monitor;
  localparam int NREG   = 16;
  localparam int BUDGET = 8000;

  typedef struct {
    int period; int offset; int pc_mode; int halt_idx; int halt_pc;
    int ready_mode; int data_rand; int sync_rand; int has_exp;
    int eh_b; int et_b; int ec_b; int eh_s; int et_s; int ec_s;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  run_monitor_if #(.PC_WIDTH(12), .NREG(16), .REG_WIDTH(4)) bif ();
  run_monitor_if #(.PC_WIDTH(12), .NREG(16), .REG_WIDTH(4)) sif ();

  run_monitor #(.PC_WIDTH(12), .ROM_SIZE(256), .NREG(16), .REG_WIDTH(4),
                .CNT_WIDTH(32), .MAX_INSTR(4096))
    u_big (.clock(clock), .reset(reset), .bus(bif));
  run_monitor #(.PC_WIDTH(12), .ROM_SIZE(256), .NREG(16), .REG_WIDTH(4),
                .CNT_WIDTH(8), .MAX_INSTR(4))
    u_small (.clock(clock), .reset(reset), .bus(sif));

  int n_cmp = 0;
  int n_bad = 0;

  // per-run trace of what was driven, indexed by clock since arm
  logic        log_sync  [BUDGET];
  logic [11:0] log_pc    [BUDGET];
  logic [3:0]  log_acc   [BUDGET];
  logic        log_carry [BUDGET];
  logic [63:0] log_regs  [BUDGET];

  int     exp_q[$];
  int     e_halt, e_tmo;
  longint e_cnt;

  int bq[$], blq[$], sq[$], slq[$];
  int b_stall_err = 0, s_stall_err = 0;
  logic b_prev_stall = 1'b0, s_prev_stall = 1'b0;
  logic [3:0] b_prev_data, s_prev_data;
  logic b_prev_last, s_prev_last;

  // collect transferred words and watch for changes during stalls
  always @(negedge clock) begin
    if (bif.arm && !bif.busy && !bif.out_valid) begin
      bq.delete(); blq.delete();
    end else if (bif.out_valid && bif.out_ready) begin
      bq.push_back(int'(bif.out_data)); blq.push_back(int'(bif.out_last));
    end
    if (!reset) b_prev_stall <= 1'b0;
    else begin
      if (b_prev_stall && !(bif.out_valid && bif.out_data == b_prev_data && bif.out_last == b_prev_last))
        b_stall_err <= b_stall_err + 1;
      b_prev_stall <= bif.out_valid && !bif.out_ready;
      b_prev_data  <= bif.out_data;
      b_prev_last  <= bif.out_last;
    end
  end

  always @(negedge clock) begin
    if (sif.arm && !sif.busy && !sif.out_valid) begin
      sq.delete(); slq.delete();
    end else if (sif.out_valid && sif.out_ready) begin
      sq.push_back(int'(sif.out_data)); slq.push_back(int'(sif.out_last));
    end
    if (!reset) s_prev_stall <= 1'b0;
    else begin
      if (s_prev_stall && !(sif.out_valid && sif.out_data == s_prev_data && sif.out_last == s_prev_last))
        s_stall_err <= s_stall_err + 1;
      s_prev_stall <= sif.out_valid && !sif.out_ready;
      s_prev_data  <= sif.out_data;
      s_prev_last  <= sif.out_last;
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic [11:0] p, input logic [3:0] a, input logic cy,
                       input logic [63:0] r, input logic rdy, input logic am);
    bif.sync = s; bif.pc = p; bif.acc = a; bif.carry = cy; bif.regs = r; bif.out_ready = rdy; bif.arm = am;
    sif.sync = s; sif.pc = p; sif.acc = a; sif.carry = cy; sif.regs = r; sif.out_ready = rdy; sif.arm = am;
  endtask

  function automatic logic [63:0] ramp_regs();
    logic [63:0] r;
    for (int k = 0; k < NREG; k++) r[k*4 +: 4] = 4'(k);
    return r;
  endfunction

  // Reference: walk the instruction syncs in order; the first one whose pc is out
  // of ROM, or which is the MAX_INSTR-th, is the stop point. The stream is then the
  // driven state at that clock plus the clocks-since-arm count (saturated).
  task automatic model(input int max_instr, input int cnt_w, input int nc);
    int n; bit hit; longint cnt, cmax;
    exp_q.delete(); e_halt = 0; e_tmo = 0; e_cnt = -1; hit = 0; n = 0;
    cmax = (longint'(1) << cnt_w) - 1;
    for (int c = 0; c < nc && !hit; c++) begin
      if (log_sync[c]) begin
        n++;
        if (log_pc[c] >= 12'd256) begin hit = 1; e_halt = 1; end
        else if (n == max_instr) begin hit = 1; e_tmo = 1; end
        if (hit) begin
          cnt = (longint'(c) > cmax) ? cmax : longint'(c);
          e_cnt = cnt;
          exp_q.push_back(int'(log_acc[c]));
          exp_q.push_back(int'(log_carry[c]));
          for (int k = 0; k < NREG; k++) exp_q.push_back(int'(log_regs[c][k*4 +: 4]));
          for (int j = 0; j < cnt_w / 4; j++) exp_q.push_back(int'((cnt >> (4*j)) & 15));
        end
      end
    end
  endtask

  task automatic run_one(input vec_t v, output int nc);
    int c, n; logic s, cy, rdy, am; logic [11:0] p; logic [3:0] a; logic [63:0] r;
    drive(1'b0, 12'd0, 4'd0, 1'b0, 64'd0, 1'b1, 1'b1);
    @(posedge clock); #1;
    chk("big busy after arm", longint'(bif.busy), 1);
    chk("small busy after arm", longint'(sif.busy), 1);
    c = 0; n = 0;
    while (!(bif.done && sif.done) && c < BUDGET) begin
      if (v.sync_rand != 0) s = ($urandom_range(32'(v.period - 1)) == 0);
      else s = (c >= v.offset) && ((c - v.offset) % v.period == 0);
      if (s) begin
        case (v.pc_mode)
          0:       p = 12'(n);
          1:       p = 12'd5;
          default: p = ($urandom_range(15) == 0) ? 12'($urandom_range(4095, 256)) : 12'($urandom_range(255));
        endcase
        if (n == v.halt_idx) p = 12'(v.halt_pc);
        n++;
      end else begin
        p = 12'($urandom_range(4095));
      end
      if (v.data_rand != 0) begin
        a = 4'($urandom); cy = 1'($urandom); r = {$urandom, $urandom};
      end else begin
        a = 4'hA; cy = 1'b1; r = ramp_regs();
      end
      case (v.ready_mode)
        0:       rdy = 1'b1;
        1:       rdy = (c % 2 == 0);
        default: rdy = 1'($urandom);
      endcase
      am = (v.sync_rand != 0) && ($urandom_range(9) == 0) && !bif.done && !sif.done;
      drive(s, p, a, cy, r, rdy, am);
      log_sync[c] = s; log_pc[c] = p; log_acc[c] = a; log_carry[c] = cy; log_regs[c] = r;
      c++;
      @(posedge clock); #1;
    end
    chk("run reached done", longint'(bif.done && sif.done), 1);
    drive(1'b0, 12'd0, 4'd0, 1'b0, 64'd0, 1'b1, 1'b0);
    nc = c;
  endtask

  task automatic check_dut(input int which, input vec_t v, input int nc);
    int got[$], lst[$]; int maxi, cw, se, eh, et, w; longint ec, gcnt; logic h, t; string tag;
    if (which == 0) begin
      got = bq; lst = blq; h = bif.halted; t = bif.timeout; se = b_stall_err;
      maxi = 4096; cw = 32; tag = "big"; eh = v.eh_b; et = v.et_b; ec = longint'(v.ec_b);
    end else begin
      got = sq; lst = slq; h = sif.halted; t = sif.timeout; se = s_stall_err;
      maxi = 4; cw = 8; tag = "small"; eh = v.eh_s; et = v.et_s; ec = longint'(v.ec_s);
    end
    model(maxi, cw, nc);
    chk({tag, " halted"}, longint'(h), longint'(e_halt));
    chk({tag, " timeout"}, longint'(t), longint'(e_tmo));
    chk({tag, " word count"}, longint'(got.size()), longint'(exp_q.size()));
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      chk($sformatf("%s word%0d {last,data}", tag, i), longint'(got[i] + 16*lst[i]),
          longint'(exp_q[i] + ((i == exp_q.size() - 1) ? 16 : 0)));
    chk({tag, " stall hold errors"}, longint'(se), 0);
    if (v.has_exp != 0) begin
      gcnt = 0; w = 2 + NREG;
      for (int j = 0; j < cw / 4; j++)
        if (w + j < got.size()) gcnt = gcnt | (longint'(got[w + j]) << (4*j));
      chk({tag, " table halted"}, longint'(h), longint'(eh));
      chk({tag, " table timeout"}, longint'(t), longint'(et));
      chk({tag, " table cycle count"}, gcnt, ec);
    end
  endtask

  initial begin
    vec_t tbl[6];
    vec_t v;
    int nc;
    //         per off pcm hidx hpc rdy drnd srnd exp  big:h t cnt   small:h t cnt
    tbl[0] = '{8, 0,   0,  9,  256, 0,  0,   0,   1,   1, 0, 72,    0, 1, 24};
    tbl[1] = '{8, 0,   1,  5,  300, 0,  0,   0,   1,   1, 0, 40,    0, 1, 24};
    tbl[2] = '{8, 0,   1,  3,  300, 0,  0,   0,   1,   1, 0, 24,    1, 0, 24};
    tbl[3] = '{8, 300, 0,  0,  300, 0,  0,   0,   1,   1, 0, 300,   1, 0, 255};
    tbl[4] = '{8, 0,   1,  2,  300, 1,  0,   0,   1,   1, 0, 16,    1, 0, 16};
    tbl[5] = '{1, 0,   1,  -1, 0,   2,  0,   0,   1,   0, 1, 4095,  0, 1, 3};

    drive(1'b0, 12'd0, 4'd0, 1'b0, 64'd0, 1'b0, 1'b0);
    reset = 1'b0;
    @(posedge clock); #1;
    chk("big outputs during reset", longint'({bif.out_valid, bif.out_last, bif.busy, bif.done, bif.halted, bif.timeout, bif.out_data}), 0);
    chk("small outputs during reset", longint'({sif.out_valid, sif.out_last, sif.busy, sif.done, sif.halted, sif.timeout, sif.out_data}), 0);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    chk("big outputs after reset", longint'({bif.out_valid, bif.out_last, bif.busy, bif.done, bif.halted, bif.timeout, bif.out_data}), 0);
    chk("small outputs after reset", longint'({sif.out_valid, sif.out_last, sif.busy, sif.done, sif.halted, sif.timeout, sif.out_data}), 0);

    for (int i = 0; i < 6; i++) begin
      run_one(tbl[i], nc);
      check_dut(0, tbl[i], nc);
      check_dut(1, tbl[i], nc);
      $display("table run %0d: clocks=%0d big h=%0d t=%0d words=%0d | small h=%0d t=%0d words=%0d",
               i, nc, bif.halted, bif.timeout, bq.size(), sif.halted, sif.timeout, sq.size());
    end

    for (int i = 0; i < 20; i++) begin
      v = '{0, 0, 2, 0, 300, 2, 1, 1, 0, 0, 0, 0, 0, 0, 0};
      v.period   = int'($urandom_range(6, 1));
      v.halt_idx = int'($urandom_range(40, 5));
      run_one(v, nc);
      check_dut(0, v, nc);
      check_dut(1, v, nc);
      $display("random run %0d: clocks=%0d big h=%0d t=%0d words=%0d | small h=%0d t=%0d words=%0d",
               i, nc, bif.halted, bif.timeout, bq.size(), sif.halted, sif.timeout, sq.size());
    end

    // reset in the middle of the drain, after word 5 has transferred
    drive(1'b0, 12'd0, 4'd0, 1'b0, 64'd0, 1'b1, 1'b1);
    @(posedge clock); #1;
    drive(1'b1, 12'd300, 4'hA, 1'b1, ramp_regs(), 1'b1, 1'b0);
    @(posedge clock); #1;
    drive(1'b0, 12'd0, 4'd0, 1'b0, 64'd0, 1'b1, 1'b0);
    for (int i = 0; i < 40 && bq.size() < 6; i++) begin
      @(posedge clock); #1;
    end
    chk("words before mid-drain reset", longint'(bq.size()), 6);
    drive(1'b0, 12'd0, 4'd0, 1'b0, 64'd0, 1'b0, 1'b0);
    reset = 1'b0;
    @(posedge clock); #1;
    chk("big state after mid-drain reset", longint'({bif.out_valid, bif.done, bif.halted, bif.busy, bif.timeout}), 0);
    chk("small state after mid-drain reset", longint'({sif.out_valid, sif.done, sif.halted, sif.busy, sif.timeout}), 0);
    chk("no transfer during reset", longint'(bq.size()), 6);
    reset = 1'b1;
    @(posedge clock); #1;
    v = '{8, 10, 1, 0, 300, 0, 0, 0, 1, 1, 0, 10, 1, 0, 10};
    run_one(v, nc);
    check_dut(0, v, nc);
    check_dut(1, v, nc);
    $display("restart after reset: clocks=%0d big h=%0d words=%0d | small h=%0d words=%0d",
             nc, bif.halted, bq.size(), sif.halted, sq.size());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/run_monitor.md
RUN_MONITOR -- requirements
Module: run_monitor

Interface
REQ-001 Parameters SHALL be (name, default, meaning): PC_WIDTH, 12, program counter width; ROM_SIZE, 256, halt threshold (halt when pc >= ROM_SIZE); NREG, 16, register count; REG_WIDTH, 4, register/word width; CNT_WIDTH, 32, cycle counter width, a multiple of REG_WIDTH; MAX_INSTR, 4096, instruction budget before timeout.
REQ-002 Ports SHALL be (name, direction, width, meaning): clock, in, 1, single clock; reset, in, 1, synchronous active-low reset.
REQ-003 sync, in, 1: one-cycle pulse marking the first clock of each CPU instruction cycle.
REQ-004 pc, in, PC_WIDTH: current program counter, valid when sync=1.
REQ-005 acc, in, REG_WIDTH: accumulator; carry, in, 1: carry flag.
REQ-006 regs, in, NREG*REG_WIDTH: register file, flattened, register k at bits [k*REG_WIDTH +: REG_WIDTH].
REQ-007 arm, in, 1: start or restart monitoring.
REQ-008 out_valid, out, 1; out_ready, in, 1; out_data, out, REG_WIDTH; out_last, out, 1: snapshot word stream.
REQ-009 busy, out, 1: state is RUN; done, out, 1: state is DONE; halted, out, 1: stop caused by pc threshold; timeout, out, 1: stop caused by instruction budget.

Function
REQ-010 States SHALL be IDLE, RUN, DRAIN, DONE; reset enters IDLE.
REQ-011 IDLE or DONE with arm=1 SHALL go to RUN next cycle, clearing cycle_count, instr_count, halted, timeout.
REQ-012 arm SHALL be ignored in RUN and DRAIN.
REQ-013 In RUN, cycle_count SHALL increment by 1 every clock, saturating at 2^CNT_WIDTH-1 (no wrap).
REQ-014 In RUN, instr_count SHALL increment on every sync=1 cycle.
REQ-015 In RUN, when sync=1 and pc >= ROM_SIZE: capture snapshot, set halted=1, go to DRAIN next cycle.
REQ-016 In RUN, when sync=1, pc < ROM_SIZE and instr_count == MAX_INSTR-1 before increment: capture snapshot, set timeout=1, go to DRAIN.
REQ-017 Simultaneous halt and timeout conditions SHALL give halted=1, timeout=0.
REQ-018 Snapshot SHALL latch acc, carry, all NREG registers and the cycle_count value of the capturing cycle (pre-increment); later input changes SHALL NOT affect it.
REQ-019 DRAIN SHALL emit W = 2 + NREG + CNT_WIDTH/REG_WIDTH words in order: acc; carry zero-extended; regs 0..NREG-1; cycle_count least-significant word first.
REQ-020 A word SHALL transfer on a cycle with out_valid=1 and out_ready=1; out_data and out_last SHALL hold stable while out_valid=1 and out_ready=0.
REQ-021 out_valid SHALL be 1 throughout DRAIN from its first cycle and 0 in all other states; back-to-back transfers at one word per clock SHALL be supported.
REQ-022 out_last SHALL be 1 only with word W-1; its transfer SHALL move the state to DONE next cycle.
REQ-023 halted and timeout SHALL remain valid through DRAIN and DONE until the next arm or reset.
REQ-024 sync outside RUN SHALL have no effect.

Reset
REQ-025 With reset=0 at a rising clock edge, the next state SHALL be IDLE, from any state including mid-DRAIN.
REQ-026 Reset SHALL clear cycle_count, instr_count, snapshot, halted, timeout and the word index to 0.
REQ-027 During and after reset, all outputs SHALL be 0 until arm.

Verification
REQ-028 Arm; sync every 8 clocks with pc 0,1,2,...; pc=256 on the 10th sync -> halted=1, timeout=0; cycle word = 72; 26 words; out_last only on word 25; done=1.
REQ-029 MAX_INSTR=4; pc held at 5; sync every 8 clocks -> timeout=1 on the 4th sync; halted=0; 26 words emitted.
REQ-030 4th sync with MAX_INSTR=4 and pc=300 -> halted=1, timeout=0.
REQ-031 acc=0xA, carry=1, regs[k]=k at capture; out_ready toggled 1/0 each cycle -> words A,1,0..F then count words, each held stable while stalled, no word lost or repeated.
REQ-032 reset=0 after word 5 of DRAIN -> next cycle out_valid=0, done=0, halted=0, state IDLE; a new arm restarts with cycle_count from 0.
REQ-033 CNT_WIDTH=8, no stop for 300 clocks, then halt -> count words F,F (saturated at 255).
